sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Parameters
REQ-001 SHALL have ADDR_WIDTH, default 3, giving pointer width and DEPTH = 2**ADDR_WIDTH = 8 entries.
REQ-002 SHALL have DATA_WIDTH, default 16, giving the data word width.
REQ-003 SHALL have RESERVE, default 2, giving the number of free entries at or below which async_full asserts.

Interface
One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  write enable.
REQ-007 data_in  input  DATA_WIDTH  word to be written.
REQ-008 wr_request  output  1  high = not full (write accepted), low = full.
REQ-009 async_empty  output  1  high when the FIFO holds zero words.
REQ-010 rd_en  input  1  read enable.
REQ-011 data_out  output  DATA_WIDTH  head word (first-word-fall-through).
REQ-012 rd_request  output  1  high = not empty (data_out valid).
REQ-013 async_full  output  1  high when free entries <= RESERVE.

Function
REQ-014 SHALL keep write pointer, read pointer (ADDR_WIDTH bits each, wrapping modulo DEPTH) and an occupancy count of ADDR_WIDTH+1 bits, range 0..DEPTH.
REQ-015 Write occurs on a clk edge iff wr_en=1 and wr_request=1: mem[wr_ptr] <= data_in, wr_ptr increments.
REQ-016 Read occurs on a clk edge iff rd_en=1 and rd_request=1: rd_ptr increments; the consumed word is the data_out value present before that edge.
REQ-017 Count: +1 on write only, -1 on read only, unchanged on simultaneous write and read or on neither.
REQ-018 wr_request = (count != DEPTH); rd_request = (count != 0); async_empty = (count == 0); async_full = (count >= DEPTH-RESERVE); all combinational from registered state.
REQ-019 data_out SHALL equal mem[rd_ptr] when rd_request=1, and all-zero when empty.
REQ-020 Write latency: a word written into an empty FIFO appears on data_out with rd_request=1 one cycle after the write edge.
REQ-021 Full: wr_en ignored (no overwrite, no pointer change); a simultaneous read proceeds, so wr_request rises on the next cycle.
REQ-022 Empty: rd_en ignored (no pointer change, no underflow); a simultaneous write proceeds.
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; order is strict first-in-first-out.
REQ-024 Memory contents are not cleared by reset and need no reset value.

Reset
REQ-025 On a clk edge with reset=1: wr_ptr=0, rd_ptr=0, count=0; reset overrides simultaneous wr_en/rd_en.
REQ-026 Outputs after reset: wr_request=1, rd_request=0, async_empty=1, async_full=0, data_out=0.
REQ-027 Reset mid-operation discards all stored words; the next write after reset is read first.

Verification
REQ-028 Reset then idle -> wr_request=1, rd_request=0, async_empty=1, async_full=0, data_out=0.
REQ-029 Write 1..8 with rd_en=0 -> async_full=1 after 6th write, wr_request=0 after 8th; 9th write (value 9) dropped, count stays 8.
REQ-030 From full, rd_en=1 for 8 cycles -> data_out sequence 1..8, then rd_request=0, async_empty=1; extra rd_en ignored.
REQ-031 Continuous wr_en=1 and rd_en=1 with incrementing data for 40 words -> output sequence exactly matches input order across multiple pointer wraps, no loss or duplication.
REQ-032 Full FIFO, simultaneous write(0xAAAA) and read -> one word read, 0xAAAA not stored, wr_request=1 next cycle.
REQ-033 Write 3 words, assert reset with wr_en=1 -> empty after reset; subsequent write 0x1234 appears as next data_out.

Source files
------------

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an early-warning "almost full" flag.
// Occupancy is tracked by an explicit counter, so full and empty never alias.
module sync_fifo #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 16,
   parameter int RESERVE    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  wr_request,
   output logic                  async_empty,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_request,
   output logic                  async_full
);

   localparam int DEPTH    = 1 << ADDR_WIDTH;
   localparam int THRESH_I = DEPTH - RESERVE;
   localparam logic [ADDR_WIDTH:0] FULL_COUNT  = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] ALMOST_FULL = THRESH_I[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  wr_fire;
   logic                  rd_fire;

   // Reset wins over both ports, so the memory is never written during reset.
   assign wr_fire = wr_en & wr_request & ~reset;
   assign rd_fire = rd_en & rd_request & ~reset;

   assign wr_request  = (count != FULL_COUNT);
   assign rd_request  = (count != '0);
   assign async_empty = (count == '0);
   assign async_full  = (count >= ALMOST_FULL);
   assign data_out    = rd_request ? mem[rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (rd_fire) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         case ({wr_fire, rd_fire})
            2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
            2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; stale words are unreachable once the pointers and count clear.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr] <= data_in;
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a queue scoreboard predicts every output each cycle,
// with explicit checks for the fill/drain, overflow, wrap and reset scenarios.
module tb_sync_fifo;

   localparam int DEPTH = 8;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic          wr_request;
   logic          async_empty;
   logic          rd_en;
   logic [DW-1:0] data_out;
   logic          rd_request;
   logic          async_full;

   logic [DW-1:0] sb [$];
   int            n_assert = 0;
   int            n_fail   = 0;

   sync_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(DW), .RESERVE(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .data_in     (data_in),
      .wr_request  (wr_request),
      .async_empty (async_empty),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .rd_request  (rd_request),
      .async_full  (async_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Compare every output against the scoreboard's view of the current state.
   task automatic check_state(input string tag);
      int n;
      n = sb.size();
      check({tag, ".wr_request"},  wr_request,  n != DEPTH);
      check({tag, ".rd_request"},  rd_request,  n != 0);
      check({tag, ".async_empty"}, async_empty, n == 0);
      check({tag, ".async_full"},  async_full,  n >= DEPTH - 2);
      check({tag, ".data_out"},    data_out,    (n > 0) ? sb[0] : '0);
   endtask

   // One clock of stimulus; called just after a rising edge, returns just after the next.
   task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd, input string tag);
      logic wf, rf;
      wr_en   = wr;
      data_in = d;
      rd_en   = rd;
      check_state(tag);
      wf = wr && (sb.size() != DEPTH);
      rf = rd && (sb.size() != 0);
      if (rf) void'(sb.pop_front());
      if (wf) sb.push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic wr);
      reset   = 1'b1;
      wr_en   = wr;
      rd_en   = 1'b0;
      data_in = 16'h5555;
      @(posedge clk);
      #1;
      reset = 1'b0;
      wr_en = 1'b0;
      sb.delete();
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      data_in = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state, then idle.
      check_state("reset");
      cycle(1'b0, '0, 1'b0, "idle");
      check_state("idle_after");

      // Fill 1..8, then a dropped ninth write.
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, DW'(i), 1'b0, $sformatf("fill%0d", i));
         if (i == 5) check("fill5.async_full", async_full, 1'b0);
         if (i == 6) check("fill6.async_full", async_full, 1'b1);
         if (i == 7) check("fill7.wr_request", wr_request, 1'b1);
         if (i == 8) check("fill8.wr_request", wr_request, 1'b0);
      end
      cycle(1'b1, 16'd9, 1'b0, "overflow");
      check("overflow.wr_request", wr_request, 1'b0);

      // Drain 1..8 in order, then extra reads on empty.
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain%0d.seq", i), data_out, 32'(i));
         cycle(1'b0, '0, 1'b1, $sformatf("drain%0d", i));
      end
      check("drained.rd_request", rd_request, 1'b0);
      check("drained.async_empty", async_empty, 1'b1);
      cycle(1'b0, '0, 1'b1, "underflow1");
      cycle(1'b0, '0, 1'b1, "underflow2");
      check_state("after_underflow");

      // Streaming across several pointer wraps.
      for (int i = 0; i < 40; i++)
         cycle(1'b1, DW'(16'h0100 + i), 1'b1, $sformatf("stream%0d", i));
      while (sb.size() != 0)
         cycle(1'b0, '0, 1'b1, "stream_drain");
      check_state("stream_done");

      // Full FIFO with simultaneous write and read.
      for (int i = 0; i < DEPTH; i++)
         cycle(1'b1, DW'(16'h0200 + i), 1'b0, "refill");
      check("refill.wr_request", wr_request, 1'b0);
      cycle(1'b1, 16'hAAAA, 1'b1, "full_wr_rd");
      check("full_wr_rd.wr_request", wr_request, 1'b1);
      check("full_wr_rd.head", data_out, 32'h0201);
      for (int i = 1; i < DEPTH; i++) begin
         check($sformatf("full_drain%0d.seq", i), data_out, 32'(16'h0200 + i));
         cycle(1'b0, '0, 1'b1, "full_drain");
      end
      check("full_drain.empty", async_empty, 1'b1);

      // Reset mid-operation with a concurrent write.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, DW'(16'h0300 + i), 1'b0, "prereset");
      do_reset(1'b1);
      check_state("midreset");
      check("midreset.data_out", data_out, 32'h0);
      cycle(1'b1, 16'h1234, 1'b0, "post_reset_wr");
      check("post_reset.data_out", data_out, 32'h1234);
      check("post_reset.rd_request", rd_request, 1'b1);
      cycle(1'b0, '0, 1'b1, "post_reset_rd");
      check_state("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
